// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS stopwatch in BCD, advanced by rising edges of a slow divider output.
//
// The divider output and the three pushbuttons are treated as asynchronous data inputs:
// each goes through a synchronizer chain and a rising-edge detector running on clk_in.
// All displayed values and status flags are registered.
//
// Ports:
//   clk_in      system clock; all state on its rising edge
//   reset       asynchronous active-low reset
//   tick_in     divider square wave; each rising edge is one second
//   btn_start   start/stop button (level, pre-debounced)
//   btn_clear   clear button (level)
//   btn_lap     lap-freeze button (level)
//   min_tens    BCD minutes tens digit
//   min_ones    BCD minutes ones digit
//   sec_tens    BCD seconds tens digit (0..5)
//   sec_ones    BCD seconds ones digit
//   running     high while counting
//   lap_active  high while the display shows the lap snapshot
//   done        high once the count has saturated at MAX_MIN:59
module stopwatch_bcd #(
  parameter int unsigned MAX_MIN     = 59,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       lap_active,
  output logic       done
);

  localparam logic [3:0] MaxMinTens = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN % 10);

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [3:0]             raw;
  logic [3:0]             sync_q [SYNC_STAGES];
  logic [3:0]             prev_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic [3:0]             ev;
  logic                   ev_tick;
  logic                   ev_start;
  logic                   ev_clear;
  logic                   ev_lap;

  assign raw = {btn_lap, btn_clear, btn_start, tick_in};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edge detection stays masked until the chain has been refilled after reset, so an input
  // that was already high when reset released is seen as a level, not as a new press.
  assign ev       = sync_q[SYNC_STAGES-1] & ~prev_q & {4{arm_q[SYNC_STAGES]}};
  assign ev_tick  = ev[0];
  assign ev_start = ev[1];
  assign ev_clear = ev[2];
  assign ev_lap   = ev[3];

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  state_e    state_q;
  bcd_time_t count_q;
  bcd_time_t snap_q;
  logic      lap_q;

  bcd_time_t count_inc;
  bcd_time_t count_adv;
  bcd_time_t count_d;
  bcd_time_t snap_d;
  bcd_time_t disp_d;
  logic      lap_d;
  logic      at_max;
  logic      do_inc;

  // BCD cascade; saturation keeps min_tens from ever passing MaxMinTens.
  always_comb begin
    count_inc = count_q;
    if (count_q.so != 4'd9) begin
      count_inc.so = count_q.so + 4'd1;
    end else begin
      count_inc.so = 4'd0;
      if (count_q.st != 4'd5) begin
        count_inc.st = count_q.st + 4'd1;
      end else begin
        count_inc.st = 4'd0;
        if (count_q.mo != 4'd9) begin
          count_inc.mo = count_q.mo + 4'd1;
        end else begin
          count_inc.mo = 4'd0;
          count_inc.mt = count_q.mt + 4'd1;
        end
      end
    end
  end

  assign at_max = (count_q == {MaxMinTens, MaxMinOnes, 4'd5, 4'd9});

  always_comb begin
    do_inc    = (state_q == StRun) && ev_tick && !at_max;
    count_adv = do_inc ? count_inc : count_q;
    count_d   = count_adv;
    snap_d    = snap_q;
    lap_d     = lap_q;
    if (ev_clear) begin
      count_d = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
    end else if (ev_lap) begin
      if (state_q inside {StRun, StPause}) begin
        lap_d = !lap_q;
        // Snapshot includes an increment landing in the same cycle.
        if (!lap_q) begin
          snap_d = count_adv;
        end
      end else if (state_q == StDone) begin
        lap_d = 1'b0;
      end
    end
    disp_d = lap_d ? snap_d : count_d;
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      snap_q     <= '0;
      lap_q      <= 1'b0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      count_q    <= count_d;
      snap_q     <= snap_d;
      lap_q      <= lap_d;
      lap_active <= lap_d;
      min_tens   <= disp_d.mt;
      min_ones   <= disp_d.mo;
      sec_tens   <= disp_d.st;
      sec_ones   <= disp_d.so;

      if (ev_clear) begin
        state_q <= StIdle;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // A tick arriving alongside the start press is not counted.
            if (ev_start) begin
              state_q <= StRun;
              running <= 1'b1;
            end
          end
          StRun: begin
            if (ev_tick && at_max) begin
              state_q <= StDone;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (ev_start) begin
              state_q <= StPause;
              running <= 1'b0;
            end
          end
          StPause: begin
            if (ev_start) begin
              state_q <= StRun;
              running <= 1'b1;
            end
          end
          StDone: begin
            // Only clear leaves DONE.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  localparam int SIdle  = 0;
  localparam int SRun   = 1;
  localparam int SPause = 2;
  localparam int SDone  = 3;

  logic clk_in    = 1'b0;
  logic reset     = 1'b0;
  logic tick_in   = 1'b0;
  logic btn_start = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_lap   = 1'b0;

  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_lap, a_done, b_run, b_lap, b_done;
  logic [18:0] obs [2];

  int total = 0;
  int bad   = 0;

  // Reference model: whole seconds as plain integers.
  int m_sec  [2];
  int m_snap [2];
  int m_st   [2];
  bit m_lap  [2];
  int m_max  [2] = '{59, 2};

  always #5 clk_in = ~clk_in;

  stopwatch_bcd u_dut_a (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .min_tens   (a_mt),
    .min_ones   (a_mo),
    .sec_tens   (a_st),
    .sec_ones   (a_so),
    .running    (a_run),
    .lap_active (a_lap),
    .done       (a_done)
  );

  stopwatch_bcd #(
    .MAX_MIN     (2),
    .SYNC_STAGES (2)
  ) u_dut_b (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_in    (tick_in),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .min_tens   (b_mt),
    .min_ones   (b_mo),
    .sec_tens   (b_st),
    .sec_ones   (b_so),
    .running    (b_run),
    .lap_active (b_lap),
    .done       (b_done)
  );

  assign obs[0] = {a_mt, a_mo, a_st, a_so, a_run, a_lap, a_done};
  assign obs[1] = {b_mt, b_mo, b_st, b_so, b_run, b_lap, b_done};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] expv(int i);
    int disp, mm, ss;
    disp = m_lap[i] ? m_snap[i] : m_sec[i];
    mm   = disp / 60;
    ss   = disp % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            m_st[i] == SRun, m_lap[i], m_st[i] == SDone};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sec[i] = 0; m_snap[i] = 0; m_st[i] = SIdle; m_lap[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(bit t, bit s, bit c, bit l);
    int prior, top;
    for (int i = 0; i < 2; i++) begin
      prior = m_st[i];
      top   = m_max[i] * 60 + 59;
      if (c) begin
        m_st[i] = SIdle; m_sec[i] = 0; m_snap[i] = 0; m_lap[i] = 1'b0;
      end else begin
        if (prior == SRun && t) begin
          if (m_sec[i] == top) m_st[i] = SDone;
          else m_sec[i] = m_sec[i] + 1;
        end
        if (s) begin
          if (prior == SIdle) m_st[i] = SRun;
          else if (prior == SPause) m_st[i] = SRun;
          else if (prior == SRun && m_st[i] == SRun) m_st[i] = SPause;
        end
        if (l) begin
          if (prior == SRun || prior == SPause) begin
            if (m_lap[i]) m_lap[i] = 1'b0;
            else begin
              m_lap[i]  = 1'b1;
              m_snap[i] = m_sec[i];
            end
          end else if (prior == SDone) begin
            m_lap[i] = 1'b0;
          end
        end
      end
    end
  endfunction

  // Advance n clocks, returning 1 time unit after the last rising edge.
  task automatic cyc(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One press / one tick; the event has been processed when this returns.
  task automatic pulse(bit t, bit s, bit c, bit l);
    tick_in = t; btn_start = s; btn_clear = c; btn_lap = l;
    cyc(2 + int'($urandom_range(0, 1)));
    tick_in = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    cyc(3 + int'($urandom_range(0, 2)));
    model_step(t, s, c, l);
  endtask

  task automatic ticks(int n);
    repeat (n) pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(3);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 19'h0) begin
        bad++; $display("FAIL reset_hold dut%0d got=%h want=%h", i, obs[i], 19'h0);
      end
    end
    reset = 1'b1;
    cyc(5);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL reset_release dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_start_latency();
    btn_start = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cyc(1);
      total++;
      if ({a_run, b_run} !== ((e == 3) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL start_latency edge%0d got=%b want=%b", e, {a_run, b_run},
                        (e == 3) ? 2'b11 : 2'b00);
      end
    end
    cyc(2);
    btn_start = 1'b0;
    cyc(6);
    model_step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL start_held_once dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_count();
    ticks(75);
    total++;
    if ({a_mt, a_mo, a_st, a_so} !== 16'h0115) begin
      bad++; $display("FAIL count_75 got=%h want=%h", {a_mt, a_mo, a_st, a_so}, 16'h0115);
    end
    ticks(4);
    total++;
    if ({a_mt, a_mo, a_st, a_so} !== 16'h0119) begin
      bad++; $display("FAIL count_0119 got=%h want=%h", {a_mt, a_mo, a_st, a_so}, 16'h0119);
    end
    ticks(1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL count_carry dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    while (m_sec[0] < 170) begin
      n = int'($urandom_range(1, 20));
      if (n > 170 - m_sec[0]) n = 170 - m_sec[0];
      ticks(n);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL sat_chunk dut%0d got=%h want=%h", i, obs[i], expv(i));
        end
      end
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(10);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL sat_frozen dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
    total++;
    if ({b_done, b_run, b_lap} !== 3'b101) begin
      bad++; $display("FAIL sat_done got=%b want=%b", {b_done, b_run, b_lap}, 3'b101);
    end
    ticks(3);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({b_mt, b_mo, b_st, b_so, b_done, b_lap} !== {16'h0259, 2'b10}) begin
      bad++; $display("FAIL sat_release got=%h want=%h", {b_mt, b_mo, b_st, b_so, b_done, b_lap},
                      {16'h0259, 2'b10});
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    while (m_sec[0] < 599) begin
      n = int'($urandom_range(1, 60));
      if (n > 599 - m_sec[0]) n = 599 - m_sec[0];
      ticks(n);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL sat_run dut%0d got=%h want=%h", i, obs[i], expv(i));
        end
      end
    end
    ticks(1);
    total++;
    if ({a_mt, a_mo, a_st, a_so} !== 16'h1000) begin
      bad++; $display("FAIL count_1000 got=%h want=%h", {a_mt, a_mo, a_st, a_so}, 16'h1000);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL sat_clear dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_pause();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(4);
    total++;
    if ({a_mt, a_mo, a_st, a_so, a_run} !== {16'h0007, 1'b0}) begin
      bad++; $display("FAIL pause_hold got=%h want=%h", {a_mt, a_mo, a_st, a_so, a_run},
                      {16'h0007, 1'b0});
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL pause_resume dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
    ticks(1);
    total++;
    if ({a_mt, a_mo, a_st, a_so, a_run} !== {16'h0008, 1'b1}) begin
      bad++; $display("FAIL pause_next got=%h want=%h", {a_mt, a_mo, a_st, a_so, a_run},
                      {16'h0008, 1'b1});
    end
  endtask

  task automatic test_lap();
    ticks(30 - m_sec[0]);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(10);
    total++;
    if ({a_mt, a_mo, a_st, a_so, a_lap} !== {16'h0030, 1'b1}) begin
      bad++; $display("FAIL lap_frozen got=%h want=%h", {a_mt, a_mo, a_st, a_so, a_lap},
                      {16'h0030, 1'b1});
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL lap_release dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    ticks(int'($urandom_range(1, 5)));
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL lap_clear dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_random();
    int r;
    bit t, s, c, l;
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 99));
      t = (r < 70) || (r >= 92 && r < 97);
      s = (r >= 70 && r < 78) || (r >= 92 && r < 95);
      l = (r >= 78 && r < 90) || (r >= 95 && r < 97);
      c = (r >= 97) || (r >= 90 && r < 92);
      pulse(t, s, c, l);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL random%0d dut%0d ev=%b%b%b%b got=%h want=%h", k, i, t, s, c, l,
                          obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(192);
    total++;
    if ({a_mt, a_mo, a_st, a_so} !== 16'h0312) begin
      bad++; $display("FAIL count_0312 got=%h want=%h", {a_mt, a_mo, a_st, a_so}, 16'h0312);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 19'h0) begin
        bad++; $display("FAIL async_reset dut%0d got=%h want=%h", i, obs[i], 19'h0);
      end
    end
    btn_start = 1'b1;
    cyc(2);
    #3;
    reset = 1'b1;
    cyc(10);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL release_held dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
    btn_start = 1'b0;
    cyc(5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL restart dut%0d got=%h want=%h", i, obs[i], expv(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_count();
    test_saturate();
    test_pause();
    test_lap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
